// File: rtl/gsram_scan_ctrl.sv
// gsram_scan_ctrl: row-major write/readout sequencer for the ROWSxCOLSxDW gSRAM
// ports: clk, rst (sync, active-high); start/mode in, busy/done/err out (control FSM side);
//   in_valid in, in_ready out (write source); gs_we/gs_row/gs_col/gs_inmuxsel out, gs_rdata in (gSRAM);
//   out_valid/out_data/out_last out, out_ready in (readout consumer)
module gsram_scan_ctrl #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          gs_we,
  output logic [AW-1:0] gs_row,
  output logic [AW-1:0] gs_col,
  output logic          gs_inmuxsel,
  input  logic [DW-1:0] gs_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t      state;
  logic        inflight, inflight_last, err_q;
  logic [1:0]  count;
  logic [DW:0] head, tail;
  logic        at_end, pop, issue, col_wrap;
  assign at_end    = gs_row == AW'(ROWS-1) && gs_col == AW'(COLS-1);
  assign col_wrap  = gs_col == AW'(COLS-1);
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign err       = err_q;
  assign in_ready  = state == WRITE;
  assign gs_we     = in_valid & in_ready;
  assign out_valid = count != 2'd0;
  assign out_data  = head[DW-1:0];
  assign out_last  = out_valid & head[DW];
  assign pop       = out_valid & out_ready;
  // words held plus the one in flight may never exceed the two FIFO slots
  assign issue     = state == READ && (3'(count) + 3'(inflight)) < (3'd2 + 3'(pop));
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gs_row        <= '0;
      gs_col        <= '0;
      gs_inmuxsel   <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_q         <= 1'b0;
      count         <= 2'd0;
      head          <= '0;
      tail          <= '0;
    end else begin
      err_q         <= state == IDLE && start && mode == 2'b11;
      inflight      <= issue;
      inflight_last <= issue && at_end;
      count         <= count + 2'(inflight) - 2'(pop);
      if (pop) head <= tail;
      if (inflight && count == 2'(pop)) head <= {inflight_last, gs_rdata};
      if (inflight && count - 2'(pop) == 2'd1) tail <= {inflight_last, gs_rdata};
      if (gs_we || issue) begin
        gs_col <= col_wrap ? '0 : gs_col + 1'b1;
        if (col_wrap) gs_row <= gs_row == AW'(ROWS-1) ? '0 : gs_row + 1'b1;
      end
      case (state)
        IDLE: if (start && mode != 2'b11) begin
          state       <= mode == 2'b10 ? READ : WRITE;
          gs_row      <= '0;
          gs_col      <= '0;
          gs_inmuxsel <= mode == 2'b00;
        end
        WRITE:   if (gs_we && at_end) state <= DONE;
        READ:    if (issue && at_end) state <= DRAIN;
        DRAIN:   if (!inflight && count == 2'(pop)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsram_scan_ctrl.sv
// tb_gsram_scan_ctrl: randomized scoreboard bench with a gSRAM model and reference array
module tb_gsram_scan_ctrl;
  localparam int ROWS = 10, COLS = 10, DW = 16, AW = 4, N = ROWS * COLS;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          busy, done, err, in_ready, gs_we, gs_inmuxsel, out_valid, out_last;
  logic [AW-1:0] gs_row, gs_col;
  logic [DW-1:0] gs_rdata, out_data, wdata;
  logic [DW-1:0] mem [ROWS][COLS];
  logic [DW-1:0] ref_mem [ROWS][COLS];
  logic [DW-1:0] src [N];
  logic [8:0]    wq [$];
  logic [DW:0]   rq [$];
  int            wr_idx = 0, pops = 0, cmp = 0, bad = 0;
  logic          stalled = 1'b0, wr_end = 1'b0;
  logic [DW:0]   held = '0;

  always #5 clk = ~clk;

  gsram_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .gs_we(gs_we), .gs_row(gs_row), .gs_col(gs_col),
    .gs_inmuxsel(gs_inmuxsel), .gs_rdata(gs_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  // gSRAM with registered read; LUT supplies src[k], M2 supplies ~src[k] for the k-th write
  assign wdata = gs_inmuxsel ? src[wr_idx % N] : ~src[wr_idx % N];
  always @(posedge clk) begin
    if (rst || (start && !busy)) wr_idx <= 0;
    else if (gs_we) wr_idx <= wr_idx + 1;
    if (gs_we && gs_row < ROWS && gs_col < COLS) mem[gs_row][gs_col] <= wdata;
    gs_rdata <= (gs_row < ROWS && gs_col < COLS) ? mem[gs_row][gs_col] : '1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic launch(logic [1:0] m);
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // monitor: pops the scoreboards whenever the DUT writes or delivers a word
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stalled = 1'b0;
      wr_end  = 1'b0;
    end else begin
      if (wr_end) chk("done_after_last_wr", 32'(done), 1);
      wr_end = gs_we && gs_row == AW'(ROWS-1) && gs_col == AW'(COLS-1);
      if (gs_we) begin
        chk("wr_pending", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) chk("wr_addr", 32'({gs_row, gs_col, gs_inmuxsel}), 32'(wq.pop_front()));
      end
      if (stalled) chk("rd_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
      if (out_valid && out_ready) begin
        pops++;
        chk("rd_pending", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) chk("rd_beat", 32'({out_last, out_data}), 32'(rq.pop_front()));
      end
    end
  end

  task automatic do_write(logic [1:0] m, int style, bit seq);
    int n = 0, err_seen = 0;
    bit got = 0;
    for (int k = 0; k < N; k++) begin
      src[k] = seq ? DW'(k) : DW'($urandom);
      ref_mem[k / COLS][k % COLS] = m == 2'b00 ? src[k] : ~src[k];
      wq.push_back({AW'(k / COLS), AW'(k % COLS), m == 2'b00});
    end
    launch(m);
    while (!got && n < 3000) begin
      in_valid = style == 0 ? 1'b1 : style == 1 ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      start = n == 37;
      if (n == 37) mode = 2'b11;
      sample();
      if (n == 0) chk("wr_cycle1", 32'({in_ready, busy, gs_row, gs_col, gs_inmuxsel}),
                      32'({1'b1, 1'b1, 4'd0, 4'd0, m == 2'b00}));
      if (err) err_seen++;
      if (done) got = 1;
      cyc();
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("wr_done", 32'(got), 1);
    chk("wr_remaining", wq.size(), 0);
    chk("wr_no_err", err_seen, 0);
    sample();
    chk("wr_idle", 32'({busy, done, in_ready}), 0);
    cyc();
  endtask

  task automatic do_read(int pct, int rst_at);
    int n = 0, first = 0, base = pops;
    bit got = 0, aborted = 0;
    for (int k = 0; k < N; k++) rq.push_back({k == N - 1, ref_mem[k / COLS][k % COLS]});
    launch(2'b10);
    while (!got && n < 3000) begin
      if (rst_at > 0 && pops - base >= rst_at) begin
        out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sample();
        chk("rst_abort", {busy, done, err, out_valid, out_last, gs_we, in_ready, gs_inmuxsel,
                          gs_row, gs_col, out_data}, 0);
        rq.delete();
        cyc();
        aborted = 1;
        break;
      end
      out_ready = $urandom_range(0, 99) < pct;
      sample();
      if (n == 0) chk("rd_cycle1", 32'({busy, gs_we, gs_inmuxsel, gs_row, gs_col}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
      if (out_valid && first == 0) first = n + 1;
      if (done) got = 1;
      cyc();
      n++;
    end
    out_ready = 1'b0;
    chk("rd_latency", first, 3);
    if (!aborted) begin
      chk("rd_done", 32'(got), 1);
      chk("rd_remaining", rq.size(), 0);
      sample();
      chk("rd_idle", 32'({busy, done, out_valid}), 0);
      cyc();
    end
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    sample();
    chk("reset_state", {busy, done, err, out_valid, out_last, gs_we, in_ready, gs_inmuxsel,
                        gs_row, gs_col, out_data}, 0);
    cyc();
    launch(2'b11);
    sample();
    chk("err_pulse", 32'({err, busy}), 32'({1'b1, 1'b0}));
    cyc();
    sample();
    chk("err_clear", 32'({err, busy}), 0);
    cyc();
    do_write(2'b00, 0, 1);
    do_read(100, 0);
    do_write(2'b01, 1, 0);
    do_read(40, 0);
    do_write(2'b00, 2, 0);
    do_read(100, 50);
    do_read(100, 0);
    do_read(70, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
